// File: rtl/scalar_branch_commit.sv
// scalar_branch_commit: ALU-downstream commit stage with a 2-entry skid buffer, branch/jump resolution and registered redirect.
//   clk, rst (async, active-high), flush
//   in_*  : ALU-side op capture (valid/ready, kind, cond, result, sign bits, pc, imm, rd)
//   out_* : head entry handshake toward write-back; wb_en/wb_rd/wb_data describe the head write
//   redirect_valid/redirect_pc : one-cycle registered fetch redirect, target held until the next one
// Sign-bit encoding: POS=2'b00, ZERO=2'b01, NEG=2'b10.
module scalar_branch_commit #(
  parameter int LEN       = 32,
  parameter int REG_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_kind,
  input  logic [2:0]           in_cond,
  input  logic [LEN-1:0]       in_result,
  input  logic [1:0]           in_sign_bits,
  input  logic [LEN-1:0]       in_pc,
  input  logic [LEN-1:0]       in_imm,
  input  logic [REG_IDX_W-1:0] in_rd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 wb_en,
  output logic [REG_IDX_W-1:0] wb_rd,
  output logic [LEN-1:0]       wb_data,
  output logic                 redirect_valid,
  output logic [LEN-1:0]       redirect_pc
);
  localparam logic [1:0] SIGN_ZERO = 2'b01;
  localparam logic [1:0] SIGN_NEG  = 2'b10;
  localparam logic [2:0] K_REG_WB  = 3'd1;
  localparam logic [2:0] K_BRANCH  = 3'd2;
  localparam logic [2:0] K_JAL     = 3'd3;
  localparam logic [2:0] K_JALR    = 3'd4;
  typedef struct packed {
    logic [2:0]           kind;
    logic [2:0]           cond;
    logic [LEN-1:0]       result;
    logic [1:0]           sign;
    logic [LEN-1:0]       pc;
    logic [LEN-1:0]       imm;
    logic [REG_IDX_W-1:0] rd;
  } entry_t;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  entry_t         ent_q [2];
  entry_t         ent_d [2];
  entry_t         head;
  state_t         state_q, state_d;
  logic           wr_ptr_q, wr_ptr_d;
  logic           rd_ptr_q, rd_ptr_d;
  logic           in_ready_q, in_ready_d;
  logic           redirect_valid_q, redirect_valid_d;
  logic [LEN-1:0] redirect_pc_q, redirect_pc_d;
  logic           in_fire, out_fire, br_taken, taken, is_link;
  logic [LEN-1:0] target;
  assign head      = ent_q[rd_ptr_q];
  assign out_valid = state_q != EMPTY;
  assign in_ready  = in_ready_q;
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;
  assign br_taken  = head.cond == 3'b000 ? head.sign == SIGN_ZERO :
                     head.cond == 3'b001 ? head.sign != SIGN_ZERO :
                     head.cond == 3'b100 ? head.sign == SIGN_NEG  :
                     head.cond == 3'b101 ? head.sign != SIGN_NEG  : 1'b0;
  assign is_link   = head.kind == K_JAL || head.kind == K_JALR;
  assign taken     = head.kind == K_BRANCH ? br_taken : is_link;
  assign target    = head.kind == K_BRANCH ? head.pc + head.imm :
                     head.kind == K_JAL    ? head.result : {head.result[LEN-1:1], 1'b0};
  assign wb_en     = out_valid && (head.kind == K_REG_WB || is_link) && head.rd != '0;
  assign wb_rd     = head.rd;
  assign wb_data   = head.kind == K_REG_WB ? head.result : is_link ? head.pc + LEN'(4) : '0;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  always_comb begin
    ent_d            = ent_q;
    state_d          = state_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    if (flush) begin
      state_d  = EMPTY;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else if (out_fire && taken) begin
      // a taken head discards every younger entry, including one arriving this cycle
      state_d          = EMPTY;
      wr_ptr_d         = 1'b0;
      rd_ptr_d         = 1'b0;
      redirect_valid_d = 1'b1;
      redirect_pc_d    = target;
    end else begin
      if (in_fire) begin
        ent_d[wr_ptr_q] = '{kind: in_kind, cond: in_cond, result: in_result, sign: in_sign_bits,
                            pc: in_pc, imm: in_imm, rd: in_rd};
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (out_fire) rd_ptr_d = ~rd_ptr_q;
      state_d = (in_fire && !out_fire) ? (state_q == EMPTY ? ONE : TWO) :
                (out_fire && !in_fire) ? (state_q == TWO ? ONE : EMPTY) : state_q;
    end
    in_ready_d = state_d != TWO;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= EMPTY;
      wr_ptr_q         <= 1'b0;
      rd_ptr_q         <= 1'b0;
      in_ready_q       <= 1'b1;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      in_ready_q       <= in_ready_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end
endmodule

// File: tb/tb_scalar_branch_commit.sv
// tb_scalar_branch_commit: directed self-checking bench for scalar_branch_commit.
module tb_scalar_branch_commit;
  localparam logic [1:0] S_POS = 2'b00, S_ZERO = 2'b01, S_NEG = 2'b10;
  localparam logic [2:0] K_NONE = 3'd0, K_REG = 3'd1, K_BR = 3'd2, K_JAL = 3'd3, K_JALR = 3'd4;
  localparam logic [2:0] BEQ = 3'b000, BNE = 3'b001, BLT = 3'b100;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, wb_en, redirect_valid;
  logic [2:0] in_kind = '0, in_cond = '0;
  logic [1:0] in_sign_bits = '0;
  logic [31:0] in_result = '0, in_pc = '0, in_imm = '0, wb_data, redirect_pc;
  logic [4:0] in_rd = '0, wb_rd;
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  scalar_branch_commit #(.LEN(32), .REG_IDX_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_cond(in_cond), .in_result(in_result), .in_sign_bits(in_sign_bits),
    .in_pc(in_pc), .in_imm(in_imm), .in_rd(in_rd), .out_valid(out_valid), .out_ready(out_ready),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask
  task automatic op(input logic [2:0] k, input logic [2:0] c, input logic [31:0] res,
                    input logic [1:0] s, input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] rd);
    in_valid = 1'b1; in_kind = k; in_cond = c; in_result = res;
    in_sign_bits = s; in_pc = pc; in_imm = imm; in_rd = rd;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_redir_v", 32'(redirect_valid), 32'd0);
    chk("rst_redir_pc", redirect_pc, 32'h0);
    rst = 1'b0;
    step();
    // 1: REG_WB presented one cycle after accept
    out_ready = 1'b1;
    op(K_REG, 3'd0, 32'h1234, S_POS, 32'h0, 32'h0, 5'd5);
    step();
    in_valid = 1'b0;
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_wb_en", 32'(wb_en), 32'd1);
    chk("t1_wb_rd", 32'(wb_rd), 32'd5);
    chk("t1_wb_data", wb_data, 32'h1234);
    step();
    chk("t1_drained", 32'(out_valid), 32'd0);
    chk("t1_no_redir", 32'(redirect_valid), 32'd0);
    // 2: BEQ taken, then BNE not taken
    out_ready = 1'b0;
    op(K_BR, BEQ, 32'h0, S_ZERO, 32'h100, 32'h20, 5'd3);
    step();
    in_valid = 1'b0;
    chk("t2_beq_wb_en", 32'(wb_en), 32'd0);
    chk("t2_beq_wb_data", wb_data, 32'h0);
    out_ready = 1'b1;
    step();
    chk("t2_beq_redir_v", 32'(redirect_valid), 32'd1);
    chk("t2_beq_redir_pc", redirect_pc, 32'h120);
    chk("t2_beq_empty", 32'(out_valid), 32'd0);
    step();
    chk("t2_beq_pulse_end", 32'(redirect_valid), 32'd0);
    chk("t2_beq_pc_held", redirect_pc, 32'h120);
    op(K_BR, BNE, 32'h0, S_ZERO, 32'h100, 32'h20, 5'd0);
    step();
    in_valid = 1'b0;
    chk("t2_bne_valid", 32'(out_valid), 32'd1);
    step();
    chk("t2_bne_no_redir", 32'(redirect_valid), 32'd0);
    chk("t2_bne_retired", 32'(out_valid), 32'd0);
    // 3: JALR link and aligned target
    out_ready = 1'b0;
    op(K_JALR, 3'd0, 32'h203, S_POS, 32'h40, 32'h0, 5'd1);
    step();
    in_valid = 1'b0;
    chk("t3_wb_en", 32'(wb_en), 32'd1);
    chk("t3_wb_rd", 32'(wb_rd), 32'd1);
    chk("t3_wb_data", wb_data, 32'h44);
    out_ready = 1'b1;
    step();
    chk("t3_redir_v", 32'(redirect_valid), 32'd1);
    chk("t3_redir_pc", redirect_pc, 32'h202);
    // 4: back-pressure and FIFO order
    out_ready = 1'b0;
    op(K_REG, 3'd0, 32'hA, S_POS, 32'h0, 32'h0, 5'd2);
    step();
    chk("t4_ready_one", 32'(in_ready), 32'd1);
    op(K_REG, 3'd0, 32'hB, S_POS, 32'h0, 32'h0, 5'd3);
    step();
    chk("t4_ready_full", 32'(in_ready), 32'd0);
    op(K_REG, 3'd0, 32'hC, S_POS, 32'h0, 32'h0, 5'd4);
    step();
    chk("t4_ready_held", 32'(in_ready), 32'd0);
    chk("t4_head_a", wb_data, 32'hA);
    out_ready = 1'b1;
    step();
    chk("t4_head_b", wb_data, 32'hB);
    chk("t4_ready_back", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("t4_head_c", wb_data, 32'hC);
    chk("t4_head_c_rd", 32'(wb_rd), 32'd4);
    step();
    chk("t4_drained", 32'(out_valid), 32'd0);
    // 5a: TWO state, taken BLT head squashes younger
    out_ready = 1'b0;
    op(K_BR, BLT, 32'hFFFF_FFF0, S_NEG, 32'h200, 32'h10, 5'd0);
    step();
    op(K_REG, 3'd0, 32'h66, S_POS, 32'h0, 32'h0, 5'd6);
    step();
    op(K_REG, 3'd0, 32'h77, S_POS, 32'h0, 32'h0, 5'd7);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t5_redir_v", 32'(redirect_valid), 32'd1);
    chk("t5_redir_pc", redirect_pc, 32'h210);
    chk("t5_squashed", 32'(out_valid), 32'd0);
    chk("t5_ready", 32'(in_ready), 32'd1);
    // 5b: ONE state, incoming op accepted in the taken-fire cycle is discarded
    out_ready = 1'b0;
    op(K_BR, BLT, 32'hFFFF_FFF0, S_NEG, 32'h300, 32'h8, 5'd0);
    step();
    op(K_REG, 3'd0, 32'h88, S_POS, 32'h0, 32'h0, 5'd8);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t5b_redir_pc", redirect_pc, 32'h308);
    chk("t5b_incoming_dropped", 32'(out_valid), 32'd0);
    // 6a: flush beats a taken head fire
    out_ready = 1'b0;
    op(K_JAL, 3'd0, 32'h400, S_POS, 32'h300, 32'h100, 5'd0);
    step();
    in_valid = 1'b0;
    chk("t6_jal_rd0_wb_en", 32'(wb_en), 32'd0);
    flush = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    chk("t6_flush_no_redir", 32'(redirect_valid), 32'd0);
    chk("t6_flush_empty", 32'(out_valid), 32'd0);
    chk("t6_flush_pc_held", redirect_pc, 32'h308);
    // 6b: asynchronous reset while TWO
    out_ready = 1'b0;
    op(K_REG, 3'd0, 32'h1, S_POS, 32'h0, 32'h0, 5'd9);
    step();
    op(K_REG, 3'd0, 32'h2, S_POS, 32'h0, 32'h0, 5'd10);
    step();
    in_valid = 1'b0;
    chk("t6_two_full", 32'(in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("t6_arst_out_valid", 32'(out_valid), 32'd0);
    chk("t6_arst_in_ready", 32'(in_ready), 32'd1);
    chk("t6_arst_redir_v", 32'(redirect_valid), 32'd0);
    chk("t6_arst_redir_pc", redirect_pc, 32'h0);
    step();
    rst = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
